// File: rtl/keypad_emulator.sv
// Keypad emulator: queues key codes and plays each one back as a timed
// press/release on a 4x4 row/column matrix seen by an external scanner.
module keypad_emulator #(
    parameter int HOLD_CYCLES = 16,
    parameter int GAP_CYCLES  = 8,
    parameter int DEPTH       = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [3:0]               key_in,
    input  logic                     key_valid,
    output logic                     key_ready,
    input  logic [3:0]               col,
    output logic [3:0]               row,
    output logic                     pressed,
    output logic [3:0]               cur_key,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic [1:0]               state,
    output logic                     done
);

    localparam int AW      = $clog2(DEPTH);
    localparam int CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LOAD  = CW'(GAP_CYCLES - 1);
    localparam logic [AW:0]   DEPTH_C   = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_PRESS   = 2'b01,
        ST_GAP     = 2'b10,
        ST_ILLEGAL = 2'b11
    } state_t;

    logic [3:0]    mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   count_r;
    logic [AW:0]   count_nxt_s;

    state_t        state_r;
    logic [CW-1:0] cnt_r;
    logic          pressed_r;
    logic [3:0]    cur_key_r;
    logic          done_r;

    logic          ready_s;
    logic          push_s;
    logic          pop_s;
    logic [3:0]    row_s;

    // Readiness looks only at the registered count, so a full queue refuses a
    // push even on the edge that pops the head.
    assign ready_s = (count_r < DEPTH_C);
    assign push_s  = key_valid && ready_s;
    assign pop_s   = (state_r == ST_IDLE) && (count_r != {(AW + 1){1'b0}});

    // Next-count selection for the push/pop combinations.
    always_comb begin
        count_nxt_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + (AW + 1)'(1);
            2'b01:   count_nxt_s = count_r - (AW + 1)'(1);
            default: count_nxt_s = count_r;
        endcase
    end

    // Queue storage; contents need no reset because the count gates every read.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= key_in;
        end
    end

    // Queue pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW + 1){1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            count_r <= count_nxt_s;
        end
    end

    // Press/release sequencer with registered pressed, cur_key and done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            cnt_r     <= {CW{1'b0}};
            pressed_r <= 1'b0;
            cur_key_r <= 4'h0;
            done_r    <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (pop_s) begin
                        cur_key_r <= mem_r[rd_ptr_r];
                        cnt_r     <= HOLD_LOAD;
                        pressed_r <= 1'b1;
                        state_r   <= ST_PRESS;
                    end else begin
                        state_r   <= ST_IDLE;
                    end
                end
                ST_PRESS: begin
                    if (cnt_r == {CW{1'b0}}) begin
                        pressed_r <= 1'b0;
                        cnt_r     <= GAP_LOAD;
                        state_r   <= ST_GAP;
                    end else begin
                        cnt_r     <= cnt_r - CW'(1);
                    end
                end
                ST_GAP: begin
                    if (cnt_r == {CW{1'b0}}) begin
                        done_r  <= 1'b1;
                        state_r <= ST_IDLE;
                    end else begin
                        cnt_r   <= cnt_r - CW'(1);
                    end
                end
                default: begin
                    // Unreachable encoding: recover to a released, idle state.
                    pressed_r <= 1'b0;
                    cnt_r     <= {CW{1'b0}};
                    state_r   <= ST_IDLE;
                end
            endcase
        end
    end

    // Row sense follows the scanner's column drive without a clock delay.
    always_comb begin
        row_s = 4'b0000;
        if (pressed_r && col[cur_key_r[1:0]]) begin
            row_s[cur_key_r[3:2]] = 1'b1;
        end else begin
            row_s = 4'b0000;
        end
    end

    assign row        = row_s;
    assign key_ready  = ready_s;
    assign fifo_count = count_r;
    assign state      = state_r;
    assign pressed    = pressed_r;
    assign cur_key    = cur_key_r;
    assign done       = done_r;

endmodule

// File: tb/tb_keypad_emulator.sv
// Self-checking bench for keypad_emulator: a timeline/queue model of key
// playback is compared against the DUT on every falling clock edge.
module tb_keypad_emulator;

    localparam int HOLD  = 16;
    localparam int GAP   = 8;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [3:0] key_in;
    logic       key_valid;
    logic       key_ready;
    logic [3:0] col;
    logic [3:0] row;
    logic       pressed;
    logic [3:0] cur_key;
    logic [2:0] fifo_count;
    logic [1:0] state;
    logic       done;

    keypad_emulator #(.HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .key_in(key_in), .key_valid(key_valid),
        .key_ready(key_ready), .col(col), .row(row), .pressed(pressed),
        .cur_key(cur_key), .fifo_count(fifo_count), .state(state), .done(done)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Model: a queue of waiting keys plus the elapsed time of the current key.
    int mq[$];
    bit m_busy = 1'b0;
    int m_e = 0;
    int m_cur = 0;
    bit m_done = 1'b0;
    bit rand_col = 1'b0;
    int dut_seq[$];
    int max_cnt = 0;
    bit prev_pressed = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_pressed();
        return m_busy && (m_e < HOLD);
    endfunction

    function automatic int m_state();
        if (!m_busy) return 0;
        return (m_e < HOLD) ? 1 : 2;
    endfunction

    function automatic int m_row();
        int c;
        c = int'(col);
        if (m_pressed() && (((c >> (m_cur % 4)) & 1) == 1)) return 1 << (m_cur / 4);
        return 0;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_busy = 1'b0;
        m_e = 0;
        m_cur = 0;
        m_done = 1'b0;
    endtask

    task automatic model_step();
        bit can_push;
        bit do_pop;
        can_push = key_valid && (mq.size() < DEPTH);
        do_pop   = !m_busy && (mq.size() > 0);
        m_done = 1'b0;
        if (do_pop) begin
            m_cur = mq.pop_front();
            m_busy = 1'b1;
            m_e = 0;
        end else if (m_busy) begin
            m_e++;
            if (m_e == HOLD + GAP) begin
                m_busy = 1'b0;
                m_done = 1'b1;
            end
        end
        if (can_push) mq.push_back(int'(key_in));
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_step();
        else model_reset();
        #2;
        if (rand_col) col = 4'($urandom);
    endtask

    task automatic push_key(input int k, input int bound, output int waited);
        bit acc;
        acc = 1'b0;
        waited = 0;
        key_in = 4'(k);
        key_valid = 1'b1;
        while (!acc && waited < bound) begin
            acc = (mq.size() < DEPTH);
            tick();
            waited++;
        end
        key_valid = 1'b0;
        if (!acc) chk("push_timeout", 0, 1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((m_busy || mq.size() != 0) && n < 500) begin
            tick();
            n++;
        end
        chk("idle_timeout", int'(state), 0);
    endtask

    // Per-cycle comparison of every DUT output against the model.
    always @(negedge clk) begin
        chk("pressed", int'(pressed), int'(m_pressed()));
        chk("cur_key", int'(cur_key), m_cur);
        chk("fifo_count", int'(fifo_count), mq.size());
        chk("state", int'(state), m_state());
        chk("done", int'(done), int'(m_done));
        chk("key_ready", int'(key_ready), int'(mq.size() < DEPTH));
        chk("row", int'(row), m_row());
        if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
        if (pressed && !prev_pressed) dut_seq.push_back(int'(cur_key));
        prev_pressed = pressed;
    end

    initial begin
        int w;
        int first;
        int hi;
        int ph[45];
        int rw[45];
        int dn_at;
        int dn_cnt;
        int h1;
        int lo;
        int h2;
        int idx;
        int exp_keys[$];

        key_in = 4'h0;
        key_valid = 1'b0;
        col = 4'hF;

        // Reset with no clock edge yet.
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_row", int'(row), 0);
        chk("rst_pressed", int'(pressed), 0);
        chk("rst_key_ready", int'(key_ready), 1);
        chk("rst_fifo_count", int'(fifo_count), 0);
        chk("rst_state", int'(state), 0);
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (2) tick();

        // Decode of key 6 (row 1, column 2).
        push_key(6, 50, w);
        first = -1;
        hi = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (pressed) begin
                hi++;
                if (first < 0) first = i;
            end
            if (i == 5) begin col = 4'b1111; #1; chk("decode_col1111", int'(row), 2); end
            if (i == 6) begin col = 4'b0100; #1; chk("decode_col0100", int'(row), 2); end
            if (i == 7) begin col = 4'b0001; #1; chk("decode_col0001", int'(row), 0); end
            if (i == 8) col = 4'b1111;
        end
        chk("press_first", first, 0);
        chk("press_len", hi, 16);
        wait_idle();

        // Ordering: F then 0, back to back.
        push_key(15, 50, w);
        key_in = 4'h0;
        key_valid = 1'b1;
        col = 4'b1000;
        dn_at = -1;
        dn_cnt = 0;
        for (int i = 0; i < 45; i++) begin
            tick();
            if (i == 0) key_valid = 1'b0;
            ph[i] = int'(pressed);
            rw[i] = int'(row);
            if (done) begin
                dn_cnt++;
                if (dn_at < 0) dn_at = i;
            end
            if (i == 15) col = 4'b0001;
        end
        h1 = 0; lo = 0; h2 = 0; idx = 0;
        while (idx < 45 && ph[idx] == 1) begin h1++; idx++; end
        while (idx < 45 && ph[idx] == 0) begin lo++; idx++; end
        while (idx < 45 && ph[idx] == 1) begin h2++; idx++; end
        chk("ord_hold1", h1, 16);
        chk("ord_gap", lo, 9);
        chk("ord_hold2", h2, 16);
        chk("ord_row_F", rw[3], 8);
        chk("ord_row_0", rw[28], 1);
        chk("ord_done_at", dn_at, 24);
        chk("ord_done_cnt", dn_cnt, 1);
        wait_idle();

        // Full queue: keys 0..5 on consecutive cycles.
        col = 4'hF;
        for (int k = 0; k < 6; k++) begin
            push_key(k, 100, w);
            if (k == 4) begin
                chk("full_count", int'(fifo_count), 4);
                chk("full_ready", int'(key_ready), 0);
            end
            if (k == 5) chk("stall_cycles", w, 23);
        end
        wait_idle();

        // Abort by reset during a press with two keys waiting.
        push_key(5, 50, w);
        push_key(9, 50, w);
        push_key(12, 50, w);
        repeat (3) tick();
        chk("abort_row_before", int'(row), 2);
        chk("abort_count_before", int'(fifo_count), 2);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("abort_row", int'(row), 0);
        chk("abort_fifo_count", int'(fifo_count), 0);
        chk("abort_pressed", int'(pressed), 0);
        chk("abort_key_ready", int'(key_ready), 1);
        chk("abort_state", int'(state), 0);
        repeat (2) tick();
        rst_n = 1'b1;
        hi = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (pressed) hi++;
        end
        chk("abort_no_press", hi, 0);

        // Wrap: ten random keys with random stalls.
        rand_col = 1'b1;
        dut_seq.delete();
        max_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            int k;
            k = int'($urandom_range(0, 15));
            exp_keys.push_back(k);
            repeat ($urandom_range(0, 6)) tick();
            push_key(k, 200, w);
        end
        wait_idle();
        chk("wrap_count", dut_seq.size(), 10);
        for (int i = 0; i < 10; i++) begin
            chk("wrap_order", (i < dut_seq.size()) ? dut_seq[i] : -1, exp_keys[i]);
        end
        chk("wrap_max_count", int'(max_cnt <= 4), 1);

        // Free-running random traffic, including keys dropped while full.
        for (int i = 0; i < 400; i++) begin
            key_valid = 1'($urandom_range(0, 1));
            key_in = 4'($urandom);
            tick();
        end
        key_valid = 1'b0;
        wait_idle();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/keypad_emulator.md
KEYPAD_EMULATOR -- requirements
Module: keypad_emulator

Interface
REQ-001 Parameter HOLD_CYCLES, default 16: clk cycles each key stays pressed; legal range >=1.
REQ-002 Parameter GAP_CYCLES, default 8: clk cycles of release after each press; legal range >=1.
REQ-003 Parameter DEPTH, default 4: key-queue depth; power of two, >=2.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 key_in  input  4  key code to queue; bits [3:2] give the row index, bits [1:0] the column index.
REQ-007 key_valid  input  1  key_in is valid this cycle.
REQ-008 key_ready  output  1  queue can accept a key this cycle.
REQ-009 col  input  4  column drive from the scanner (1111 = all columns, one-hot = single column).
REQ-010 row  output  4  row sense returned to the scanner.
REQ-011 pressed  output  1  a key is currently held.
REQ-012 cur_key  output  4  code of the key being held, or the last key held.
REQ-013 fifo_count  output  clog2(DEPTH)+1  number of queued keys.
REQ-014 state  output  2  FSM state: 00 IDLE, 01 PRESS, 10 GAP.
REQ-015 done  output  1  one-cycle pulse when a press/release sequence completes.

Function
REQ-016 Queue: synchronous FIFO of DEPTH 4-bit entries; push on the clk edge where key_valid && key_ready.
REQ-017 key_ready = (fifo_count < DEPTH), registered-count based only; when full, no push is accepted even on a simultaneous pop.
REQ-018 Push with key_valid high and key_ready low: key dropped, no state change; the sender must hold key_valid.
REQ-019 Simultaneous push and pop: fifo_count unchanged, order preserved.
REQ-020 FIFO pointers wrap modulo DEPTH; FIFO order is strictly first-in first-out.
REQ-021 IDLE: if fifo_count>0, pop the head into cur_key, load the counter with HOLD_CYCLES-1, set pressed=1, go to PRESS; otherwise stay in IDLE.
REQ-022 PRESS: decrement the counter; at 0, clear pressed, load the counter with GAP_CYCLES-1, go to GAP.
REQ-023 GAP: decrement the counter; at 0, pulse done for one cycle, go to IDLE.
REQ-024 Timing: pressed high exactly HOLD_CYCLES cycles, then low exactly GAP_CYCLES cycles, then at least 1 IDLE cycle; back-to-back key period = HOLD_CYCLES+GAP_CYCLES+1.
REQ-025 Latency: a key pushed into an empty FIFO during IDLE is popped on the next edge; pressed is visible one cycle after acceptance.
REQ-026 row is combinational from col and registered state: row[cur_key[3:2]] = pressed && col[cur_key[1:0]]; all other row bits 0.
REQ-027 Consequence of REQ-026: col=1111 or the matching one-hot column returns the one-hot row; a non-matching column returns 0000.
REQ-028 Illegal state encoding 11: go to IDLE on the next edge with pressed=0.
REQ-029 cur_key holds its value after release until the next pop.

Reset
REQ-030 rst_n low asynchronously forces: state=IDLE, pressed=0, row=0000, cur_key=0000, counter=0, FIFO pointers=0, fifo_count=0, done=0, key_ready=1.
REQ-031 Reset mid-PRESS or mid-GAP: the sequence aborts immediately and queued keys are discarded.
REQ-032 Release of rst_n: normal operation from the first rising clk edge with rst_n high.

Verification (HOLD_CYCLES=16, GAP_CYCLES=8, DEPTH=4)
REQ-033 Reset: assert rst_n=0 with no clk edge -> row=0000, pressed=0, key_ready=1, fifo_count=0, state=00.
REQ-034 Decode: push key 6 -> pressed high 16 cycles from one cycle after acceptance; col=1111 gives row=0010; col=0100 gives row=0010; col=0001 gives row=0000.
REQ-035 Full: push keys 0,1,2,3,4,5 on consecutive cycles -> key 0 is popped; fifo_count reaches 4; key_ready=0; key 5 is stalled until key 0's done pulse, then accepted.
REQ-036 Ordering: queue F then 0 -> F held 16 cycles with row=1000 at col=1000; 8 low cycles; done pulse; 1 IDLE cycle; 0 held 16 cycles with row=0001 at col=0001.
REQ-037 Abort: rst_n low at cycle 5 of PRESS with 2 keys queued -> row=0000 immediately, fifo_count=0, no further presses.
REQ-038 Wrap: push 10 keys with random stalls -> all 10 keys are pressed in order; fifo_count never exceeds 4.
